// File: rtl/execution_stage.sv
// MIPS EX stage: ALU-control decode, operand-B / destination muxes, 32-bit ALU, registered EX/MEM word.
// Optional feature macro: EXEC_OVERFLOW_EN enables signed ADD/SUB overflow reporting on ex_mem[70].
module execution_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [135:0] id_ex,
  output logic [74:0]  ex_mem
);

  typedef struct packed {
    logic       regdst;
    logic       memwrite;
    logic       memtoreg;
    logic [1:0] aluop;
    logic       memread;
    logic       alusrc;
    logic       regwrite;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] imm;
    logic [31:0] rd2;
    logic [31:0] rd1;
    logic [31:0] instr;
  } id_ex_t;

  typedef struct packed {
    logic        regwrite;
    logic        memwrite;
    logic        memtoreg;
    logic        memread;
    logic        overflow;
    logic        zero;
    logic [4:0]  write_reg;
    logic [31:0] rd2;
    logic [31:0] result;
  } ex_mem_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_ADDU = 4'b1000;
  localparam logic [3:0] ALU_SUBU = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  id_ex_t      in;
  ex_mem_t     nxt, q;
  logic [31:0] a, b, res;
  logic [32:0] slt_diff;
  logic [4:0]  shamt, write_reg;
  logic [5:0]  funct;
  logic [3:0]  code;
  logic        ovf;
  logic        unused_instr;

  assign in    = id_ex_t'(id_ex);
  assign funct = in.instr[5:0];
  assign shamt = in.instr[10:6];
  assign a     = in.rd1;
  assign b     = in.ctrl.alusrc ? in.imm : in.rd2;
  assign write_reg = in.ctrl.regdst ? in.instr[15:11] : in.instr[20:16];
  // opcode/rs fields are decoded upstream
  assign unused_instr = ^in.instr[31:21];

  always_comb begin
    code = ALU_ADD;
    case (in.ctrl.aluop)
      2'b00: code = ALU_ADD;
      2'b01: code = ALU_SUB;
      2'b11: code = ALU_SLT;
      default: begin
        case (funct)
          6'h20: code = ALU_ADD;
          6'h21: code = ALU_ADDU;
          6'h22: code = ALU_SUB;
          6'h23: code = ALU_SUBU;
          6'h24: code = ALU_AND;
          6'h25: code = ALU_OR;
          6'h27: code = ALU_NOR;
          6'h2A: code = ALU_SLT;
          6'h00: code = ALU_SLL;
          6'h02: code = ALU_SRL;
          6'h03: code = ALU_SRA;
          default: code = ALU_ADD;
        endcase
      end
    endcase
  end

  // 33-bit signed compare keeps SLT right when A-B overflows 32 bits
  assign slt_diff = {a[31], a} - {b[31], b};

  always_comb begin
    res = '0;
    case (code)
      ALU_ADD, ALU_ADDU: res = a + b;
      ALU_SUB, ALU_SUBU: res = a - b;
      ALU_AND:           res = a & b;
      ALU_OR:            res = a | b;
      ALU_NOR:           res = ~(a | b);
      ALU_SLT:           res = {31'd0, slt_diff[32]};
      ALU_SLL:           res = b << shamt;
      ALU_SRL:           res = b >> shamt;
      ALU_SRA:           res = $unsigned($signed(b) >>> shamt);
      default:           res = '0;
    endcase
  end

`ifdef EXEC_OVERFLOW_EN
  always_comb begin
    ovf = 1'b0;
    if (code == ALU_ADD)
      ovf = (a[31] == b[31]) && (res[31] != a[31]);
    else if (code == ALU_SUB)
      ovf = (a[31] != b[31]) && (res[31] != a[31]);
  end
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    nxt.regwrite  = in.ctrl.regwrite;
    nxt.memwrite  = in.ctrl.memwrite;
    nxt.memtoreg  = in.ctrl.memtoreg;
    nxt.memread   = in.ctrl.memread;
    nxt.overflow  = ovf;
    nxt.zero      = (res == 32'd0);
    nxt.write_reg = write_reg;
    nxt.rd2       = in.rd2;
    nxt.result    = res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= nxt;
  end

  assign ex_mem = q;

endmodule

// File: tb/tb_execution_stage.sv
// Randomized + directed bench for execution_stage against an operation-level reference model.
module tb_execution_stage;

`ifdef EXEC_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [135:0] id_ex;
  logic [74:0]  ex_mem;

  execution_stage dut (.clk(clk), .rst_n(rst_n), .id_ex(id_ex), .ex_mem(ex_mem));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;
  bit lit_valid = 1'b0;
  logic [74:0] lit_val = '0;
  string lit_name = "";
  logic [74:0] exp_q = '0;
  event check_now;

  function automatic logic [74:0] model(input logic [135:0] w);
    logic [31:0] instr, a, d2, imm, b, r;
    logic [7:0]  c;
    logic [4:0]  wr, sh;
    longint      sa, sb, full;
    logic        v;
    string       op;
    instr = w[31:0]; a = w[63:32]; d2 = w[95:64]; imm = w[127:96]; c = w[135:128];
    b  = c[1] ? imm : d2;
    wr = c[7] ? instr[15:11] : instr[20:16];
    sh = instr[10:6];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c[4:3])
      2'b00: op = "add";
      2'b01: op = "sub";
      2'b11: op = "slt";
      default: case (instr[5:0])
        6'h21: op = "addu"; 6'h22: op = "sub";  6'h23: op = "subu";
        6'h24: op = "and";  6'h25: op = "or";   6'h27: op = "nor";
        6'h2A: op = "slt";  6'h00: op = "sll";  6'h02: op = "srl";
        6'h03: op = "sra";  default: op = "add";
      endcase
    endcase
    v = 1'b0;
    full = 0;
    case (op)
      "add", "addu": begin full = sa + sb; r = 32'(full); end
      "sub", "subu": begin full = sa - sb; r = 32'(full); end
      "and": r = a & b;
      "or":  r = a | b;
      "nor": r = ~(a | b);
      "slt": r = (sa < sb) ? 32'd1 : 32'd0;
      "sll": r = b << sh;
      "srl": r = b >> sh;
      "sra": r = 32'(sb >>> sh);
      default: r = 32'd0;
    endcase
    // exact 64-bit result must survive truncation to 32 signed bits
    if (OVF_ON && (op == "add" || op == "sub"))
      v = (full != longint'($signed(r)));
    return {c[0], c[6], c[5], c[2], v, (r == 32'd0), wr, d2, r};
  endfunction

  function automatic logic [74:0] em(input logic [31:0] res, input logic [31:0] d2, input logic [4:0] wr,
                                     input bit z, input bit ov, input bit mr, input bit mtr, input bit mw, input bit rw);
    return {rw, mw, mtr, mr, ov, z, wr, d2, res};
  endfunction

  function automatic logic [135:0] mkw(input logic [31:0] instr, input logic [31:0] d1, input logic [31:0] d2,
                                       input logic [31:0] imm, input logic [7:0] ctrl);
    return {ctrl, imm, d2, d1, instr};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {6'd0, 5'd18, rt, rd, sh, fn};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= '0;
    else        exp_q <= model(id_ex);
  end

  always begin
    @(negedge clk or check_now);
    if (armed) begin
      vectors++;
      if (ex_mem !== exp_q) begin
        miscompares++;
        $display("FAIL model t=%0t: ex_mem=%h required %h", $time, ex_mem, exp_q);
      end
      if (lit_valid) begin
        vectors++;
        if (ex_mem !== lit_val) begin
          miscompares++;
          $display("FAIL %s: ex_mem=%h required %h", lit_name, ex_mem, lit_val);
        end
      end
    end
  end

  task automatic apply(input logic [135:0] w);
    id_ex = w;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_lit(input string name, input logic [74:0] val);
    lit_name  = name;
    lit_val   = val;
    lit_valid = 1'b1;
    @(negedge clk);
    #1 lit_valid = 1'b0;
  endtask

  function automatic logic [135:0] rand_word();
    logic [31:0] instr, d1, d2, imm;
    logic [5:0]  fl [12];
    fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h3F};
    instr = $urandom;
    if ($urandom_range(1, 0) == 1) instr[5:0] = fl[$urandom_range(11, 0)];
    d1 = $urandom; d2 = $urandom; imm = $urandom;
    case ($urandom_range(5, 0))
      0: d1 = 32'h7FFFFFFF;
      1: d1 = 32'h80000000;
      2: d2 = d1;
      3: imm = d1;
      default: ;
    endcase
    if ($urandom_range(3, 0) == 0) d2 = ($urandom_range(1, 0) == 1) ? 32'h80000000 : 32'd1;
    return mkw(instr, d1, d2, imm, 8'($urandom));
  endfunction

  initial begin
    rst_n = 1'b1;
    id_ex = rand_word();
    #1 rst_n = 1'b0;
    #1 armed = 1'b1;
    lit_name = "reset_async"; lit_val = '0; lit_valid = 1'b1;
    -> check_now;
    #1 lit_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    apply(mkw(32'h02518820, 32'd5, 32'd5, 32'd10, 8'h91));
    expect_lit("add", em(32'd10, 32'd5, 5'd17, 0, 0, 0, 0, 0, 1));
    apply(mkw(32'h02518822, 32'd7, 32'd5, 32'd10, 8'h91));
    expect_lit("sub", em(32'd2, 32'd5, 5'd17, 0, 0, 0, 0, 0, 1));
    apply(mkw(32'h02518822, 32'd5, 32'd5, 32'd10, 8'h91));
    expect_lit("sub_zero", em(32'd0, 32'd5, 5'd17, 1, 0, 0, 0, 0, 1));
    apply(mkw(32'h8C09FFFC, 32'd100, 32'd7, 32'hFFFFFFFC, 8'h27));
    expect_lit("load_addr", em(32'd96, 32'd7, 5'd9, 0, 0, 1, 1, 0, 1));
    apply(mkw(32'h02518820, 32'h7FFFFFFF, 32'd1, 32'd0, 8'h91));
    expect_lit("add_ovf", em(32'h80000000, 32'd1, 5'd17, 0, OVF_ON, 0, 0, 0, 1));
    apply(mkw(32'h02518821, 32'h7FFFFFFF, 32'd1, 32'd0, 8'h91));
    expect_lit("addu_noovf", em(32'h80000000, 32'd1, 5'd17, 0, 0, 0, 0, 0, 1));
    apply(mkw(rtype(5'd17, 5'd17, 5'd4, 6'h03), 32'h12345678, 32'hF0000000, 32'd0, 8'h91));
    expect_lit("sra", em(32'hFF000000, 32'hF0000000, 5'd17, 0, 0, 0, 0, 0, 1));
    apply(mkw(rtype(5'd17, 5'd17, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'd1, 32'd0, 8'h91));
    expect_lit("slt_neg", em(32'd1, 32'd1, 5'd17, 0, 0, 0, 0, 0, 1));
    apply(mkw(rtype(5'd17, 5'd17, 5'd0, 6'h3F), 32'd3, 32'd4, 32'd0, 8'h91));
    expect_lit("unknown_funct", em(32'd7, 32'd4, 5'd17, 0, 0, 0, 0, 0, 1));

    for (int i = 0; i < 400; i++) begin
      apply(rand_word());
      if (i % 37 == 36) begin
        // mid-stream reset drops the in-flight word without waiting for a clock
        rst_n = 1'b0;
        lit_name = "reset_mid"; lit_val = '0; lit_valid = 1'b1;
        #1 -> check_now;
        #1 lit_valid = 1'b0;
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
